// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - tightly-coupled data RAM responding on the core dmem bus with wait states
// Optional feature: define DMEM_RESP_RANGE_CHECK_EN to flag addresses outside the RAM window with dmem_err.
package dmem_responder_pkg;
    typedef enum logic [2:0] {
        BYTE  = 3'b000,
        HWORD = 3'b001,
        WORD  = 3'b010,
        DWORD = 3'b011,
        QWORD = 3'b100
    } biu_size_t;
endpackage

module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter int               DEPTH       = 1024,
    parameter logic [XLEN-1:0]  BASE_ADR    = '0,
    parameter int               WAIT_STATES = 1
) (
    input  logic            rstn,
    input  logic            clk,
    input  logic            dmem_req,
    input  logic [XLEN-1:0] dmem_adr,
    input  logic [XLEN-1:0] dmem_d,
    input  logic            dmem_we,
    input  biu_size_t       dmem_size,
    output logic [XLEN-1:0] dmem_q,
    output logic            dmem_ack,
    output logic            dmem_err,
    output logic            dmem_misaligned,
    output logic            dmem_page_fault
);
    localparam int         AW      = $clog2(DEPTH);
    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES - 1);
`ifdef DMEM_RESP_RANGE_CHECK_EN
    localparam logic [XLEN:0] SPAN = (XLEN+1)'(DEPTH) << 2;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic [XLEN-1:0] req_adr;
    logic [XLEN-1:0] req_d;
    logic            req_we;
    biu_size_t       req_size;

    logic [XLEN-1:0] mem [DEPTH];

    // Returns {err, misaligned}; illegal size and out-of-range win over misalignment.
    function automatic logic [1:0] classify(input logic [1:0] lo, input biu_size_t size, input logic oor);
        logic illegal;
        logic mis;
        illegal = !(size inside {BYTE, HWORD, WORD});
        mis     = ((size == HWORD) && lo[0]) || ((size == WORD) && (lo != 2'b00));
        return {illegal | oor, mis & ~illegal & ~oor};
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] lo, input biu_size_t size);
        logic [3:0] be;
        case (size)
            BYTE:    be = 4'b0001 << lo;
            HWORD:   be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] old, input logic [XLEN-1:0] d,
                                              input logic [3:0] be);
        logic [XLEN-1:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    logic            accept;
    logic            from_wait;
    logic            go_ack;
    logic [XLEN-1:0] src_adr;
    logic            src_we;
    biu_size_t       src_size;
    logic [XLEN:0]   src_diff;
    logic [XLEN:0]   req_diff;
    logic [AW-1:0]   src_idx;
    logic [AW-1:0]   req_idx;
    logic            src_oor;
    logic            req_oor;
    logic [1:0]      src_flags;
    logic [1:0]      req_flags;
    logic [3:0]      req_be;
    logic            commit;
    logic [XLEN-1:0] rd_word;
    logic            unused_diff;

    assign accept    = dmem_req && (state == S_IDLE || state == S_ACK);
    assign from_wait = (state == S_WAIT);
    assign go_ack    = (from_wait && cnt == 4'd0) || (accept && WAIT_STATES == 0);

    // With zero wait states the ack is decided from the live bus, otherwise from the captured request.
    assign src_adr  = from_wait ? req_adr  : dmem_adr;
    assign src_we   = from_wait ? req_we   : dmem_we;
    assign src_size = from_wait ? req_size : dmem_size;

    // The extra top bit catches addresses below BASE_ADR as huge offsets.
    assign src_diff = {1'b0, src_adr} - {1'b0, BASE_ADR};
    assign req_diff = {1'b0, req_adr} - {1'b0, BASE_ADR};
    assign src_idx  = src_diff[AW+1:2];
    assign req_idx  = req_diff[AW+1:2];
    assign unused_diff = ^{src_diff, req_diff};

`ifdef DMEM_RESP_RANGE_CHECK_EN
    assign src_oor = (src_diff >= SPAN);
    assign req_oor = (req_diff >= SPAN);
`else
    assign src_oor = 1'b0;
    assign req_oor = 1'b0;
`endif

    assign src_flags = classify(src_adr[1:0], src_size, src_oor);
    assign req_flags = classify(req_adr[1:0], req_size, req_oor);
    assign req_be    = byte_en(req_adr[1:0], req_size);
    assign commit    = (state == S_ACK) && req_we && (req_flags == 2'b00);

    // A store committing on this edge is forwarded into a same-word load acked on the same edge.
    assign rd_word = (commit && req_idx == src_idx) ? merge(mem[src_idx], req_d, req_be) : mem[src_idx];

    assign dmem_page_fault = 1'b0;

    always_ff @(posedge clk) begin
        if (commit) mem[req_idx] <= merge(mem[req_idx], req_d, req_be);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= S_IDLE;
            cnt             <= 4'd0;
            req_adr         <= '0;
            req_d           <= '0;
            req_we          <= 1'b0;
            req_size        <= BYTE;
            dmem_ack        <= 1'b0;
            dmem_err        <= 1'b0;
            dmem_misaligned <= 1'b0;
            dmem_q          <= '0;
        end else begin
            dmem_ack        <= go_ack;
            dmem_err        <= go_ack & src_flags[1];
            dmem_misaligned <= go_ack & src_flags[0];
            dmem_q          <= (go_ack && !src_we && src_flags == 2'b00) ? rd_word : '0;
            if (accept) begin
                req_adr  <= dmem_adr;
                req_d    <= dmem_d;
                req_we   <= dmem_we;
                req_size <= dmem_size;
                if (WAIT_STATES == 0) begin
                    state <= S_ACK;
                end else begin
                    state <= S_WAIT;
                    cnt   <= WS_INIT;
                end
            end else if (state == S_WAIT) begin
                if (cnt == 4'd0) state <= S_ACK;
                else             cnt   <= cnt - 4'd1;
            end else begin
                state <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder with 1 and 0 wait states
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    typedef struct {
        logic [31:0] q;
        logic        err;
        logic        mis;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    exp_t        sb1[$];
    exp_t        sb0[$];

    logic        req1 = 1'b0, we1 = 1'b0;
    logic [31:0] adr1 = '0, d1 = '0;
    biu_size_t   size1 = WORD;
    logic [31:0] q1;
    logic        ack1, err1, mis1, pf1;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [31:0] adr0 = '0, d0 = '0;
    biu_size_t   size0 = WORD;
    logic [31:0] q0;
    logic        ack0, err0, mis0, pf0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    dmem_responder #(.XLEN(32), .DEPTH(1024), .BASE_ADR(32'h0), .WAIT_STATES(1)) u_dut1 (
        .rstn(rstn), .clk(clk), .dmem_req(req1), .dmem_adr(adr1), .dmem_d(d1), .dmem_we(we1),
        .dmem_size(size1), .dmem_q(q1), .dmem_ack(ack1), .dmem_err(err1),
        .dmem_misaligned(mis1), .dmem_page_fault(pf1)
    );

    dmem_responder #(.XLEN(32), .DEPTH(1024), .BASE_ADR(32'h0), .WAIT_STATES(0)) u_dut0 (
        .rstn(rstn), .clk(clk), .dmem_req(req0), .dmem_adr(adr0), .dmem_d(d0), .dmem_we(we0),
        .dmem_size(size0), .dmem_q(q0), .dmem_ack(ack0), .dmem_err(err0),
        .dmem_misaligned(mis0), .dmem_page_fault(pf0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboards whenever a responder acks; idle cycles must be quiet.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rstn) begin
            if (ack1) begin
                total++;
                if (sb1.size() == 0) begin
                    bad++;
                    $display("FAIL ws1_ack unexpected ack actual=1 expected=0");
                end else begin
                    e = sb1.pop_front();
                    chk({e.name, "_q"}, q1, e.q);
                    chk({e.name, "_err"}, err1, e.err);
                    chk({e.name, "_mis"}, mis1, e.mis);
                    chk({e.name, "_cyc"}, cyc, e.cyc);
                    chk({e.name, "_pf"}, pf1, 0);
                end
            end else begin
                chk("ws1_idle_quiet", {q1[31:3], q1[2:0] | {err1, mis1, pf1}}, 0);
            end
            if (ack0) begin
                total++;
                if (sb0.size() == 0) begin
                    bad++;
                    $display("FAIL ws0_ack unexpected ack actual=1 expected=0");
                end else begin
                    e = sb0.pop_front();
                    chk({e.name, "_q"}, q0, e.q);
                    chk({e.name, "_err"}, err0, e.err);
                    chk({e.name, "_mis"}, mis0, e.mis);
                    chk({e.name, "_cyc"}, cyc, e.cyc);
                    chk({e.name, "_pf"}, pf0, 0);
                end
            end else begin
                chk("ws0_idle_quiet", {q0[31:3], q0[2:0] | {err0, mis0, pf0}}, 0);
            end
        end
    end

    // One request on the 1-wait-state responder: accepted on the next edge, acked two edges later.
    task automatic issue1(input logic we, input biu_size_t sz, input logic [31:0] adr, input logic [31:0] d,
                          input logic [31:0] eq, input logic ee, input logic em, input string name);
        @(negedge clk);
        req1 = 1'b1; we1 = we; size1 = sz; adr1 = adr; d1 = d;
        sb1.push_back('{eq, ee, em, cyc + 2, name});
        @(negedge clk);
        req1 = 1'b0;
        @(negedge clk);
    endtask

    // Back-to-back requests on the 0-wait-state responder; req stays high until idle0.
    task automatic issue0(input logic we, input biu_size_t sz, input logic [31:0] adr, input logic [31:0] d,
                          input logic [31:0] eq, input logic ee, input logic em, input string name);
        @(negedge clk);
        req0 = 1'b1; we0 = we; size0 = sz; adr0 = adr; d0 = d;
        sb0.push_back('{eq, ee, em, cyc + 1, name});
    endtask

    task automatic idle0();
        @(negedge clk);
        req0 = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ws1_q"}, q1, 0);
        chk({tag, "_ws1_flags"}, {ack1, err1, mis1, pf1}, 0);
        chk({tag, "_ws0_q"}, q0, 0);
        chk({tag, "_ws0_flags"}, {ack0, err0, mis0, pf0}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rstn = 1'b1;

        issue1(1, WORD,  32'h10, 32'hDEADBEEF, 32'h0,        0, 0, "st_word_10");
        issue1(0, WORD,  32'h10, 32'h0,        32'hDEADBEEF, 0, 0, "ld_word_10");
        issue1(1, WORD,  32'h10, 32'h11223344, 32'h0,        0, 0, "st_word_10b");
        issue1(1, BYTE,  32'h13, 32'hAAAAAAAA, 32'h0,        0, 0, "st_byte_13");
        issue1(0, WORD,  32'h10, 32'h0,        32'hAA223344, 0, 0, "ld_after_byte");
        issue1(0, BYTE,  32'h13, 32'h0,        32'hAA223344, 0, 0, "ld_byte_fullword");
        issue1(1, WORD,  32'h20, 32'h0BADF00D, 32'h0,        0, 0, "st_word_20");
        issue1(1, HWORD, 32'h21, 32'hFFFFFFFF, 32'h0,        0, 1, "st_hword_21_mis");
        issue1(0, WORD,  32'h20, 32'h0,        32'h0BADF00D, 0, 0, "ld_20_unchanged");
        issue1(1, HWORD, 32'h22, 32'hCAFECAFE, 32'h0,        0, 0, "st_hword_22");
        issue1(0, HWORD, 32'h20, 32'h0,        32'hCAFEF00D, 0, 0, "ld_20_hword");
        issue1(0, WORD,  32'h22, 32'h0,        32'h0,        0, 1, "ld_word_22_mis");
        issue1(1, DWORD, 32'h25, 32'h12345678, 32'h0,        1, 0, "st_dword_err");
        issue1(0, biu_size_t'(3'd7), 32'h20, 32'h0, 32'h0,   1, 0, "ld_size7_err");
        issue1(1, WORD,  32'h0,  32'h600DCAFE, 32'h0,        0, 0, "st_word_0");
`ifdef DMEM_RESP_RANGE_CHECK_EN
        issue1(0, WORD,  32'h1000, 32'h0,      32'h0,        1, 0, "ld_out_of_range");
`else
        issue1(0, WORD,  32'h1000, 32'h0,      32'h600DCAFE, 0, 0, "ld_wrap_range");
`endif
        issue1(1, WORD,  32'h40, 32'h55667788, 32'h0,        0, 0, "st_word_40");

        // Store abandoned by reset while it waits: no ack, no write.
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; size1 = WORD; adr1 = 32'h40; d1 = 32'h99999999;
        @(negedge clk);
        req1 = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midreset");
        @(negedge clk);
        chk_reset_outputs("midreset2");
        rstn = 1'b1;
        @(negedge clk);
        issue1(0, WORD,  32'h40, 32'h0,        32'h55667788, 0, 0, "ld_40_after_reset");

        issue0(1, WORD,  32'h0,  32'h01010101, 32'h0,        0, 0, "b2b_st_0");
        issue0(1, WORD,  32'h4,  32'h02020202, 32'h0,        0, 0, "b2b_st_4");
        issue0(1, WORD,  32'h8,  32'h03030303, 32'h0,        0, 0, "b2b_st_8");
        issue0(1, WORD,  32'hC,  32'h04040404, 32'h0,        0, 0, "b2b_st_c");
        issue0(0, WORD,  32'h0,  32'h0,        32'h01010101, 0, 0, "b2b_ld_0");
        issue0(0, WORD,  32'h4,  32'h0,        32'h02020202, 0, 0, "b2b_ld_4");
        issue0(0, WORD,  32'h8,  32'h0,        32'h03030303, 0, 0, "b2b_ld_8");
        issue0(0, WORD,  32'hC,  32'h0,        32'h04040404, 0, 0, "b2b_ld_c");
        idle0();
        issue0(1, BYTE,  32'h5,  32'hEEEEEEEE, 32'h0,        0, 0, "b2b_st_byte_5");
        issue0(0, WORD,  32'h4,  32'h0,        32'h0202EE02, 0, 0, "b2b_ld_fwd_4");
        idle0();
        issue0(0, WORD,  32'h4,  32'h0,        32'h0202EE02, 0, 0, "ld_4_settled");
        idle0();
        issue0(1, WORD,  32'h9,  32'hFFFFFFFF, 32'h0,        0, 1, "b2b_st_9_mis");
        issue0(0, WORD,  32'h8,  32'h0,        32'h03030303, 0, 0, "b2b_ld_8_nofwd");
        idle0();

        repeat (4) @(negedge clk);
        chk("ws1_pending_acks", sb1.size(), 0);
        chk("ws0_pending_acks", sb0.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
